// File: rtl/key_scheduler_if.sv
// key_scheduler_if: handshake and key bus between the AES-128 round datapath and key_scheduler.
//   start      master->slave  load cipherKey and begin a new schedule
//   cipherKey  master->slave  128-bit initial key, sampled with start
//   next       master->slave  current roundKey consumed, request the following one
//   roundKey   slave->master  current round key, w0 in [127:96], w3 in [31:0]
//   roundNum   slave->master  index of roundKey, 0..10
//   keyValid   slave->master  roundKey/roundNum valid
//   busy       slave->master  schedule in progress
//   done       slave->master  one-cycle pulse after round key 10 is consumed
interface key_scheduler_if;
   logic         start;
   logic [127:0] cipherKey;
   logic         next;
   logic [127:0] roundKey;
   logic [3:0]   roundNum;
   logic         keyValid;
   logic         busy;
   logic         done;

   modport master (
      output start, cipherKey, next,
      input  roundKey, roundNum, keyValid, busy, done
   );

   modport slave (
      input  start, cipherKey, next,
      output roundKey, roundNum, keyValid, busy, done
   );
endinterface

// File: rtl/key_scheduler.sv
// key_scheduler: on-the-fly AES-128 key expansion, one round key per accepted request.
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   keyIf  slave side of key_scheduler_if (start/cipherKey/next in, roundKey/roundNum/
//          keyValid/busy/done out)
// Only the current 128-bit round key is held; the next one is derived combinationally from it.
module key_scheduler (
   input  logic            clk,
   input  logic            rst,
   key_scheduler_if.slave  keyIf
);

   typedef enum logic [0:0] {StIdle, StRun} stateT;

   localparam logic [7:0] Sbox [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Rcon for the transition out of round idx; idx 10..15 never reach the key register.
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      unique case (idx)
         4'd0:    rcon = 8'h01;
         4'd1:    rcon = 8'h02;
         4'd2:    rcon = 8'h04;
         4'd3:    rcon = 8'h08;
         4'd4:    rcon = 8'h10;
         4'd5:    rcon = 8'h20;
         4'd6:    rcon = 8'h40;
         4'd7:    rcon = 8'h80;
         4'd8:    rcon = 8'h1b;
         4'd9:    rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   stateT        state;
   logic [127:0] roundKeyQ;
   logic [3:0]   roundNumQ;
   logic         doneQ;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  rotW, subW, t;
   logic [31:0]  w0n, w1n, w2n, w3n;
   logic [127:0] nextKey;

   always_comb begin
      w0      = roundKeyQ[127:96];
      w1      = roundKeyQ[95:64];
      w2      = roundKeyQ[63:32];
      w3      = roundKeyQ[31:0];
      rotW    = {w3[23:0], w3[31:24]};
      subW    = {Sbox[rotW[31:24]], Sbox[rotW[23:16]], Sbox[rotW[15:8]], Sbox[rotW[7:0]]};
      t       = subW ^ {rcon(roundNumQ), 24'h0};
      w0n     = w0 ^ t;
      w1n     = w1 ^ w0n;
      w2n     = w2 ^ w1n;
      w3n     = w3 ^ w2n;
      nextKey = {w0n, w1n, w2n, w3n};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         roundKeyQ <= '0;
         roundNumQ <= '0;
         doneQ     <= 1'b0;
      end else begin
         doneQ <= 1'b0;
         unique case (state)
            StIdle: begin
               if (keyIf.start) begin
                  state     <= StRun;
                  roundKeyQ <= keyIf.cipherKey;
                  roundNumQ <= '0;
               end
            end
            StRun: begin
               // A restart wins over a pending request, including the final one.
               if (keyIf.start) begin
                  roundKeyQ <= keyIf.cipherKey;
                  roundNumQ <= '0;
               end else if (keyIf.next) begin
                  if (roundNumQ == 4'd10) begin
                     state <= StIdle;
                     doneQ <= 1'b1;
                  end else begin
                     roundKeyQ <= nextKey;
                     roundNumQ <= roundNumQ + 4'd1;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign keyIf.roundKey = roundKeyQ;
   assign keyIf.roundNum = roundNumQ;
   assign keyIf.keyValid = (state == StRun);
   assign keyIf.busy     = (state == StRun);
   assign keyIf.done     = doneQ;

endmodule

// File: tb/tb_key_scheduler.sv
module tb_key_scheduler;

   localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FipsR1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FipsR2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] FipsR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZeroR1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZeroR10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   key_scheduler_if kif ();

   key_scheduler dut (
      .clk   (clk),
      .rst   (rst),
      .keyIf (kif)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; kif.start = 1'b1; kif.next = 1'b1; kif.cipherKey = FipsKey;
      tick(); tick();
      checks++;
      if ({kif.roundKey, kif.roundNum, kif.keyValid, kif.busy, kif.done} !== 135'd0) begin
         errors++;
         $display("FAIL reset_outputs: key=%h num=%0d valid=%b busy=%b done=%b, required all 0",
                  kif.roundKey, kif.roundNum, kif.keyValid, kif.busy, kif.done);
      end
      rst = 1'b0; kif.start = 1'b0;
      tick(); tick();
      checks++;
      if ({kif.roundKey, kif.roundNum, kif.keyValid, kif.busy, kif.done} !== 135'd0) begin
         errors++;
         $display("FAIL reset_release: key=%h num=%0d valid=%b busy=%b done=%b, required all 0",
                  kif.roundKey, kif.roundNum, kif.keyValid, kif.busy, kif.done);
      end
      kif.next = 1'b0;
   endtask

   task automatic test_fips;
      kif.start = 1'b1; kif.cipherKey = FipsKey;
      tick();
      kif.start = 1'b0;
      checks++;
      if (kif.roundKey !== FipsKey || kif.roundNum !== 4'd0 || kif.keyValid !== 1'b1
          || kif.busy !== 1'b1) begin
         errors++;
         $display("FAIL fips_r0: key=%h num=%0d valid=%b busy=%b, required %h 0 1 1",
                  kif.roundKey, kif.roundNum, kif.keyValid, kif.busy, FipsKey);
      end
      kif.next = 1'b1;
      for (int r = 1; r <= 10; r++) begin
         tick();
         checks++;
         if (kif.roundNum !== r[3:0] || kif.keyValid !== 1'b1 || kif.done !== 1'b0) begin
            errors++;
            $display("FAIL fips_num: num=%0d valid=%b done=%b, required %0d 1 0",
                     kif.roundNum, kif.keyValid, kif.done, r);
         end
         if (r == 1 || r == 2 || r == 10) begin
            logic [127:0] exp;
            exp = (r == 1) ? FipsR1 : (r == 2) ? FipsR2 : FipsR10;
            checks++;
            if (kif.roundKey !== exp) begin
               errors++;
               $display("FAIL fips_key r%0d: got %h, required %h", r, kif.roundKey, exp);
            end
         end
      end
      tick();
      checks++;
      if (kif.done !== 1'b1 || kif.keyValid !== 1'b0 || kif.busy !== 1'b0
          || kif.roundNum !== 4'd10 || kif.roundKey !== FipsR10) begin
         errors++;
         $display("FAIL fips_done: done=%b valid=%b busy=%b num=%0d key=%h, required 1 0 0 10 %h",
                  kif.done, kif.keyValid, kif.busy, kif.roundNum, kif.roundKey, FipsR10);
      end
      kif.next = 1'b0;
      tick();
      checks++;
      if (kif.done !== 1'b0) begin
         errors++;
         $display("FAIL done_width: done=%b, required 0", kif.done);
      end
   endtask

   // Runs right after test_fips: block sits in IDLE with round 10 held.
   task automatic test_idle_overrun;
      for (int i = 0; i < 3; i++) begin
         kif.next = 1'b1; tick();
         kif.next = 1'b0; tick();
         checks++;
         if (kif.keyValid !== 1'b0 || kif.roundNum !== 4'd10 || kif.done !== 1'b0
             || kif.roundKey !== FipsR10) begin
            errors++;
            $display("FAIL overrun: valid=%b num=%0d done=%b key=%h, required 0 10 0 %h",
                     kif.keyValid, kif.roundNum, kif.done, kif.roundKey, FipsR10);
         end
      end
      rst = 1'b1; tick(); rst = 1'b0;
      kif.next = 1'b1; tick(); tick(); kif.next = 1'b0; tick();
      checks++;
      if ({kif.roundKey, kif.roundNum, kif.keyValid, kif.busy, kif.done} !== 135'd0) begin
         errors++;
         $display("FAIL idle_next: key=%h num=%0d valid=%b, required all 0",
                  kif.roundKey, kif.roundNum, kif.keyValid);
      end
   endtask

   task automatic test_stall;
      int stalls [10] = '{0, 3, 1, 2, 0, 1, 3, 0, 2, 1};
      logic [127:0] held;
      kif.start = 1'b1; kif.cipherKey = '0;
      tick();
      kif.start = 1'b0;
      for (int r = 1; r <= 10; r++) begin
         held = kif.roundKey;
         for (int s = 0; s < stalls[r-1]; s++) begin
            tick();
            checks++;
            if (kif.roundKey !== held || kif.roundNum !== 4'(r - 1) || kif.keyValid !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold: key=%h num=%0d valid=%b, required %h %0d 1",
                        kif.roundKey, kif.roundNum, kif.keyValid, held, r - 1);
            end
         end
         kif.next = 1'b1; tick(); kif.next = 1'b0;
         checks++;
         if (kif.roundNum !== r[3:0]) begin
            errors++;
            $display("FAIL stall_num: got %0d, required %0d", kif.roundNum, r);
         end
         if (r == 1 || r == 10) begin
            logic [127:0] exp;
            exp = (r == 1) ? ZeroR1 : ZeroR10;
            checks++;
            if (kif.roundKey !== exp) begin
               errors++;
               $display("FAIL zero_key r%0d: got %h, required %h", r, kif.roundKey, exp);
            end
         end
      end
      kif.next = 1'b1; tick(); kif.next = 1'b0;
      checks++;
      if (kif.done !== 1'b1 || kif.keyValid !== 1'b0) begin
         errors++;
         $display("FAIL stall_done: done=%b valid=%b, required 1 0", kif.done, kif.keyValid);
      end
      tick();
   endtask

   task automatic test_restart;
      int doneSeen = 0;
      kif.start = 1'b1; kif.cipherKey = FipsKey;
      tick();
      kif.start = 1'b0; kif.next = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      // start and next together at round 4: restart must win
      kif.start = 1'b1; kif.cipherKey = '0;
      tick();
      kif.start = 1'b0;
      checks++;
      if (kif.roundNum !== 4'd0 || kif.roundKey !== 128'd0 || kif.done !== 1'b0
          || kif.keyValid !== 1'b1) begin
         errors++;
         $display("FAIL restart: num=%0d key=%h done=%b valid=%b, required 0 0 0 1",
                  kif.roundNum, kif.roundKey, kif.done, kif.keyValid);
      end
      for (int r = 1; r <= 10; r++) begin
         tick();
         if (kif.done === 1'b1) doneSeen++;
         if (r == 1 || r == 10) begin
            logic [127:0] exp;
            exp = (r == 1) ? ZeroR1 : ZeroR10;
            checks++;
            if (kif.roundKey !== exp || kif.roundNum !== r[3:0]) begin
               errors++;
               $display("FAIL restart_key r%0d: got %h num=%0d, required %h", r, kif.roundKey,
                        kif.roundNum, exp);
            end
         end
      end
      checks++;
      if (doneSeen != 0) begin
         errors++;
         $display("FAIL restart_nodone: done pulses=%0d, required 0", doneSeen);
      end
      // start while round 10 is consumed: completion discarded
      kif.start = 1'b1; kif.cipherKey = FipsKey;
      tick();
      kif.start = 1'b0; kif.next = 1'b0;
      checks++;
      if (kif.done !== 1'b0 || kif.roundNum !== 4'd0 || kif.roundKey !== FipsKey
          || kif.keyValid !== 1'b1) begin
         errors++;
         $display("FAIL start_at_done: done=%b num=%0d key=%h valid=%b, required 0 0 %h 1",
                  kif.done, kif.roundNum, kif.roundKey, kif.keyValid, FipsKey);
      end
      tick();
      checks++;
      if (kif.done !== 1'b0) begin
         errors++;
         $display("FAIL start_at_done_late: done=%b, required 0", kif.done);
      end
   endtask

   task automatic test_reset_midrun;
      int doneSeen = 0;
      kif.start = 1'b1; kif.cipherKey = FipsKey;
      tick();
      kif.start = 1'b0; kif.next = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (kif.roundNum !== 4'd6) begin
         errors++;
         $display("FAIL midrun_num: got %0d, required 6", kif.roundNum);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({kif.roundKey, kif.roundNum, kif.keyValid, kif.busy, kif.done} !== 135'd0) begin
         errors++;
         $display("FAIL midrun_reset: key=%h num=%0d valid=%b done=%b, required all 0",
                  kif.roundKey, kif.roundNum, kif.keyValid, kif.done);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (kif.done === 1'b1) doneSeen++;
      end
      kif.next = 1'b0;
      checks++;
      if (doneSeen != 0) begin
         errors++;
         $display("FAIL midrun_nodone: done pulses=%0d, required 0", doneSeen);
      end
      kif.start = 1'b1; kif.cipherKey = FipsKey;
      tick();
      kif.start = 1'b0;
      checks++;
      if (kif.roundKey !== FipsKey || kif.roundNum !== 4'd0 || kif.keyValid !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_start: key=%h num=%0d valid=%b, required %h 0 1",
                  kif.roundKey, kif.roundNum, kif.keyValid, FipsKey);
      end
      kif.next = 1'b1; tick(); kif.next = 1'b0;
      checks++;
      if (kif.roundKey !== FipsR1 || kif.roundNum !== 4'd1) begin
         errors++;
         $display("FAIL post_reset_r1: key=%h num=%0d, required %h 1",
                  kif.roundKey, kif.roundNum, FipsR1);
      end
   endtask

   initial begin
      rst = 1'b1; kif.start = 1'b0; kif.next = 1'b0; kif.cipherKey = '0;
      test_reset();
      test_fips();
      test_idle_overrun();
      test_stall();
      test_restart();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
